// File: rtl/seq_serializer.sv
// Parallel-to-serial shifter: first bit on x one cycle after accept, one bit per cycle, optional trailing even-parity bit (SEQ_SERIALIZER_PARITY_EN).
// Backpressure: din_ready only in IDLE or on the final frame bit, so a held-off word simply waits with the producer.
module seq_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SEQ_SERIALIZER_PARITY_EN
   localparam logic [1:0] ST_PAR   = 2'd2;

   logic par_q, par_d;
`endif

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             last_data;
   logic             last_bit;
   logic             accept;

   always_comb begin
      last_data = (state_q == ST_SHIFT) && (idx_q == LAST_IDX);
`ifdef SEQ_SERIALIZER_PARITY_EN
      last_bit  = (state_q == ST_PAR);
`else
      last_bit  = last_data;
`endif
      din_ready  = (state_q == ST_IDLE) || last_bit;
      accept     = din_valid && din_ready;
      x_valid    = (state_q != ST_IDLE);
      busy       = (state_q != ST_IDLE);
      frame_done = last_bit;
   end

   // The outgoing bit always sits at the register end facing the shift direction.
   always_comb begin
      x = 1'b0;
      if (state_q == ST_SHIFT) begin
         x = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      else if (state_q == ST_PAR) begin
         x = par_q;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sreg_d  = sreg_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         state_d = ST_SHIFT;
         idx_d   = '0;
         sreg_d  = din;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_d   = ^din;
`endif
      end else if (state_q == ST_SHIFT) begin
         if (last_data) begin
            idx_d   = '0;
            sreg_d  = '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
`endif
         end else begin
            idx_d  = idx_q + CW'(1);
            sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
         end
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      else if (state_q == ST_PAR) begin
         state_d = ST_IDLE;
         par_d   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sreg_q  <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sreg_q  <= sreg_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
